// File: rtl/axi4lite_master_bridge.sv
// rtl/axi4lite_master_bridge.sv - single-outstanding valid/ready command to AXI4-Lite master bridge
//
// Takes one command at a time, either a read or a write, and issues it on the AXI4-Lite
// master channels. The read data and the response code are returned on the rsp port.
// All outputs are registered.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cmd_*                 command request (valid/ready): we, addr, wdata, wstrb, qos
//   rsp_*                 response (valid/ready): we echo, rdata (0 for writes), resp
//   aw_*, w_*, b_*        AXI4-Lite write address, write data and write response channels
//   ar_*, r_*             AXI4-Lite read address and read data channels

module axi4lite_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 1,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  input  logic [3:0]            cmd_qos,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [RESP_WIDTH-1:0] rsp_resp,
  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic [3:0]            aw_qos,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [STRB_WIDTH-1:0] w_strb,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic [RESP_WIDTH-1:0] b_resp,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [3:0]            ar_qos,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [RESP_WIDTH-1:0] r_resp,
  input  logic                  r_valid,
  output logic                  r_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      aw_addr   <= '0;
      aw_qos    <= '0;
      aw_valid  <= 1'b0;
      w_data    <= '0;
      w_strb    <= '0;
      w_valid   <= 1'b0;
      b_ready   <= 1'b0;
      ar_addr   <= '0;
      ar_qos    <= '0;
      ar_valid  <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes up on the first cycle out of reset and stays up while idle
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            aw_addr   <= cmd_addr;
            ar_addr   <= cmd_addr;
            aw_qos    <= cmd_qos;
            ar_qos    <= cmd_qos;
            w_data    <= cmd_wdata;
            w_strb    <= cmd_wstrb;
            rsp_we    <= cmd_we;
            if (cmd_we) begin
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= WR_REQ;
            end else begin
              ar_valid <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // aw and w retire independently; a channel is done once its valid is low
          // or its handshake is happening on this edge
          if (aw_valid && aw_ready) aw_valid <= 1'b0;
          if (w_valid && w_ready)   w_valid  <= 1'b0;
          if ((!aw_valid || aw_ready) && (!w_valid || w_ready)) begin
            b_ready <= 1'b1;
            state   <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (b_valid && b_ready) begin
            rsp_resp  <= b_resp;
            rsp_rdata <= '0;
            b_ready   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RD_REQ: begin
          if (ar_valid && ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (r_valid && r_ready) begin
            rsp_rdata <= r_data;
            rsp_resp  <= r_resp;
            r_ready   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// tb/tb_axi4lite_master_bridge.sv - directed vector bench for axi4lite_master_bridge

module tb_axi4lite_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic [3:0]  cmd_qos = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        rsp_resp;
  logic [31:0] aw_addr;
  logic [3:0]  aw_qos;
  logic        aw_valid;
  logic        aw_ready = 1'b0;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic        b_resp = 1'b0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic [3:0]  ar_qos;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [31:0] r_data = '0;
  logic        r_resp = 1'b0;
  logic        r_valid = 1'b0;
  logic        r_ready;

  axi4lite_master_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_qos(cmd_qos),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .aw_addr(aw_addr), .aw_qos(aw_qos), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_qos(ar_qos), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  qos;
    logic [31:0] s_rdata;
    logic        s_resp;
    logic [31:0] exp_rdata;
    logic        exp_resp;
  } vec_t;

  vec_t vecs[4];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_resp = 1'b0;
    r_valid = 1'b0; r_resp = 1'b0; r_data = '0;
    rsp_ready = 1'b0;
  endtask

  // Waits (bounded) for cmd_ready, presents one command for one handshake edge,
  // and returns one cycle after the handshake.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [3:0] qos);
    for (int k = 0; k < 20 && !cmd_ready; k++) step();
    chk("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr;
    cmd_wdata = wdata; cmd_wstrb = wstrb; cmd_qos = qos;
    step();
    cmd_valid = 1'b0;
  endtask

  // Minimum-latency transaction against an always-ready slave.
  task automatic run_vec(input int i);
    aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
    b_valid = 1'b1; b_resp = vecs[i].s_resp;
    r_valid = 1'b1; r_resp = vecs[i].s_resp; r_data = vecs[i].s_rdata;
    rsp_ready = 1'b1;
    issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].qos);
    if (vecs[i].we) begin
      chk("c1_aw_valid", aw_valid, 1);
      chk("c1_w_valid", w_valid, 1);
      chk("c1_ar_valid", ar_valid, 0);
      chk("c1_aw_addr", aw_addr, vecs[i].addr);
      chk("c1_aw_qos", aw_qos, vecs[i].qos);
      chk("c1_w_data", w_data, vecs[i].wdata);
      chk("c1_w_strb", w_strb, vecs[i].wstrb);
    end else begin
      chk("c1_ar_valid", ar_valid, 1);
      chk("c1_aw_valid", aw_valid, 0);
      chk("c1_ar_addr", ar_addr, vecs[i].addr);
      chk("c1_ar_qos", ar_qos, vecs[i].qos);
    end
    step();
    if (vecs[i].we) begin
      chk("c2_b_ready", b_ready, 1);
      chk("c2_aw_valid", aw_valid, 0);
      chk("c2_w_valid", w_valid, 0);
    end else begin
      chk("c2_r_ready", r_ready, 1);
      chk("c2_ar_valid", ar_valid, 0);
    end
    chk("c2_rsp_valid", rsp_valid, 0);
    step();
    chk("c3_rsp_valid", rsp_valid, 1);
    chk("c3_rsp_we", rsp_we, vecs[i].we);
    chk("c3_rsp_rdata", rsp_rdata, vecs[i].exp_rdata);
    chk("c3_rsp_resp", rsp_resp, vecs[i].exp_resp);
    chk("c3_b_ready", b_ready, 0);
    chk("c3_r_ready", r_ready, 0);
    step();
    chk("c4_rsp_valid", rsp_valid, 0);
    chk("c4_cmd_ready", cmd_ready, 1);
    slave_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    //         we    addr          wdata         strb  qos   s_rdata       s_resp exp_rdata     exp_resp
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'h0, 4'h0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
    vecs[2] = '{1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'h3, 4'h5, 32'h5555_AAAA, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h1111_1111, 4'hF, 4'hA, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0};

    // Reset state
    slave_idle();
    rst_i = 1'b1;
    step(); step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_aw_addr", aw_addr, 0);
    rst_i = 1'b0;
    step();
    chk("rst_release_cmd_ready", cmd_ready, 1);

    // Table-driven minimum-latency transactions
    for (int i = 0; i < 4; i++) run_vec(i);

    // Skewed write: w completes at cycle 1, aw only at cycle 4
    slave_idle();
    issue(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'h5, 4'h3);
    chk("skew_c1_aw_valid", aw_valid, 1);
    chk("skew_c1_w_valid", w_valid, 1);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    chk("skew_w_dropped", w_valid, 0);
    for (int k = 0; k < 3; k++) begin
      chk("skew_aw_held", aw_valid, 1);
      chk("skew_aw_addr_stable", aw_addr, 32'h0000_0020);
      chk("skew_b_ready_low", b_ready, 0);
      if (k == 2) aw_ready = 1'b1;
      step();
    end
    aw_ready = 1'b0;
    chk("skew_aw_dropped", aw_valid, 0);
    chk("skew_b_ready_up", b_ready, 1);
    b_valid = 1'b1; b_resp = 1'b1; rsp_ready = 1'b1;
    step();
    b_valid = 1'b0;
    chk("skew_rsp_valid", rsp_valid, 1);
    chk("skew_rsp_resp", rsp_resp, 1);
    chk("skew_rsp_rdata", rsp_rdata, 0);
    chk("skew_rsp_we", rsp_we, 1);
    chk("skew_b_ready_low_after", b_ready, 0);
    step();
    chk("skew_cmd_ready_back", cmd_ready, 1);
    slave_idle();

    // Read with r_valid delayed 5 cycles, then rsp_ready held low 4 cycles
    ar_ready = 1'b1;
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0, 4'h0);
    chk("bp_ar_valid", ar_valid, 1);
    step();
    ar_ready = 1'b0;
    chk("bp_ar_dropped", ar_valid, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_r_ready_wait", r_ready, 1);
      step();
    end
    chk("bp_r_ready_at_rvalid", r_ready, 1);
    r_valid = 1'b1; r_data = 32'hCAFE_F00D; r_resp = 1'b0;
    step();
    r_valid = 1'b0; r_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      chk("bp_rsp_valid_held", rsp_valid, 1);
      chk("bp_rsp_rdata_stable", rsp_rdata, 32'hCAFE_F00D);
      chk("bp_rsp_we_stable", rsp_we, 0);
      chk("bp_cmd_ready_low", cmd_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    chk("bp_rsp_valid_at_hs", rsp_valid, 1);
    step();
    rsp_ready = 1'b0;
    chk("bp_rsp_valid_dropped", rsp_valid, 0);
    chk("bp_cmd_ready_back", cmd_ready, 1);

    // Stray responses while idle are ignored
    b_valid = 1'b1; b_resp = 1'b1; r_valid = 1'b1;
    step();
    chk("stray_b_ready", b_ready, 0);
    chk("stray_r_ready", r_ready, 0);
    chk("stray_rsp_valid", rsp_valid, 0);
    chk("stray_cmd_ready", cmd_ready, 1);
    slave_idle();
    run_vec(1);

    // Reset in WR_REQ with aw_valid high
    slave_idle();
    issue(1'b1, 32'h0000_0030, 32'h1357_9BDF, 4'hF, 4'h1);
    chk("mid_aw_valid", aw_valid, 1);
    rst_i = 1'b1;
    step();
    chk("mid_rst_aw_valid", aw_valid, 0);
    chk("mid_rst_w_valid", w_valid, 0);
    chk("mid_rst_ar_valid", ar_valid, 0);
    chk("mid_rst_b_ready", b_ready, 0);
    chk("mid_rst_r_ready", r_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    rst_i = 1'b0;
    step();
    chk("mid_rst_release_cmd_ready", cmd_ready, 1);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4lite_master_bridge.md
Name: axi4lite_master_bridge

Overview:
Single-outstanding AXI4-Lite initiator that converts a simple valid/ready command port into AXI4-Lite read or write transactions. It drives the master side of axi4lite_intf, which is the counterpart of the slave modport used by the timer register block. It serves as the bus driver for the timer subsystem bring-up, CPU-less test harnesses and DMA-style configuration sequencers. It returns read data and the response code on a valid/ready response port.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr, aw_addr, ar_addr
DATA_WIDTH, 32, width of write/read data; must be a multiple of 8
RESP_WIDTH, 1, width of r_resp, b_resp, rsp_resp
STRB_WIDTH, DATA_WIDTH/8, derived byte-strobe width (localparam)

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_we  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  STRB_WIDTH  write byte strobes
cmd_qos  in  4  QoS value, copied to aw_qos/ar_qos
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_we  out  1  echo of cmd_we for this response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  RESP_WIDTH  r_resp or b_resp captured from the slave
aw_addr, aw_qos, aw_valid  out  ADDR_WIDTH,4,1  write address channel
aw_ready  in  1
w_data, w_strb, w_valid  out  DATA_WIDTH,STRB_WIDTH,1  write data channel
w_ready  in  1
b_resp, b_valid  in  RESP_WIDTH,1  write response channel
b_ready  out  1
ar_addr, ar_qos, ar_valid  out  ADDR_WIDTH,4,1  read address channel
ar_ready  in  1
r_data, r_resp, r_valid  in  DATA_WIDTH,RESP_WIDTH,1  read data channel
r_ready  out  1

Behaviour:
- All outputs are registered. Reset values: every valid output = 0, b_ready = 0, r_ready = 0, cmd_ready = 0, all data/address/qos/resp outputs = 0. FSM state = IDLE.
- One transaction is outstanding at a time. cmd_ready = 1 only in IDLE; it rises on the first cycle after reset deasserts.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE, on a cmd handshake:
  - Latch addr, wdata, wstrb, we and qos; drop cmd_ready.
  - Write: next cycle assert aw_valid and w_valid together; go to WR_REQ.
  - Read: next cycle assert ar_valid; go to RD_REQ.
- WR_REQ:
  - aw and w complete independently. aw_valid drops the cycle after aw_valid & aw_ready; w_valid drops the cycle after w_valid & w_ready.
  - Both may complete in the same cycle or in either order.
  - Once both are done, go to WR_RESP with b_ready = 1.
  - AXI rule: neither valid is deasserted or changed before its ready is seen.
- WR_RESP: on b_valid & b_ready, capture b_resp into rsp_resp, set rsp_rdata = 0, drop b_ready; go to RSP.
- RD_REQ: on ar_valid & ar_ready, drop ar_valid, raise r_ready; go to RD_RESP.
- RD_RESP: on r_valid & r_ready, capture r_data and r_resp, drop r_ready; go to RSP.
- RSP:
  - rsp_valid = 1, with payload held stable until rsp_ready.
  - On handshake, drop rsp_valid, return to IDLE and raise cmd_ready the next cycle.
- Minimum latency, with the slave always ready and rsp_ready = 1:
  - Write: cmd handshake at cycle 0; aw/w handshake at cycle 1; b handshake at cycle 2; rsp_valid high at cycle 3.
  - Read: same timing, with ar in cycle 1 and r in cycle 2.
- Stray b_valid or r_valid outside its RESP state is ignored, since the matching ready is 0.
- rsp_resp is passed through verbatim; the block does not interpret error codes.
- Reset mid-transaction: all valids and readies drop in the same edge and the FSM returns to IDLE. Any partial AXI transaction is abandoned; the slave is reset by the same rst_i.
- No timeout. A slave that never responds stalls the block indefinitely; this is by design.

Test Plan:
- Write, slave always ready: cmd_we = 1, addr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 0xF, b_resp 0.
  - aw/w seen at cycle 1 with those values; rsp_valid at cycle 3 with rsp_we = 1, rsp_rdata = 0, rsp_resp = 0.
- Read, slave always ready: addr 0x0000_0004, r_data 0x1234_5678, r_resp 1.
  - ar_addr = 0x4 at cycle 1; rsp_rdata = 0x1234_5678 and rsp_resp = 1 at cycle 3.
- Skewed write channels: aw_ready asserted 3 cycles after w_ready.
  - w_valid drops after its own handshake; aw_valid stays high with a stable address until aw_ready.
  - b_ready rises only after both handshakes complete.
- Backpressure:
  - r_valid delayed 5 cycles: r_ready stays 1 throughout.
  - rsp_ready held 0 for 4 cycles: rsp payload is stable and cmd_ready stays 0 until the rsp handshake.
- Stray response: b_valid = 1 pulsed while idle.
  - No state change, b_ready stays 0; the next read completes normally.
- Reset mid-operation: assert rst_i during WR_REQ with aw_valid = 1.
  - Next cycle all valids/readies = 0 and cmd_ready = 0; cmd_ready = 1 the cycle after rst_i falls.
